// File: rtl/hamming_stream_encoder_if.sv
// Valid/ready stream bundle for the Hamming(7,4) encoder: nibble input side and codeword
// output side. The encoder uses the slave modport; the stimulus/consumer uses master.
interface hamming_stream_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       select;
  logic [2:0] inj_pos;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output select,
    output inj_pos,
    input  out_valid,
    output out_ready,
    input  out_data
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  select,
    input  inj_pos,
    output out_valid,
    input  out_ready,
    output out_data
  );
endinterface

// File: rtl/hamming_stream_encoder.sv
// Streaming Hamming(7,4) encoder with per-word parity select, optional single-bit error
// injection and a 2-entry output FIFO whose occupancy is tracked by a small FSM.
module hamming_stream_encoder #(
  parameter int unsigned CNT_W  = 16,
  parameter bit          INJ_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  hamming_stream_encoder_if.slave  bus,
  output logic [CNT_W-1:0]         cw_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e     state_q, state_d;
  logic [6:0] head_q, head_d;   // entry shown on out_data
  logic [6:0] tail_q, tail_d;   // second entry, valid only in StFull
  logic       in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       push, pop;
  logic [6:0] cw_enc;
  logic [6:0] inj_mask;
  logic       d1, d2, d3, d4, p1, p2, p4;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = bus.out_valid & bus.out_ready;

  // Encode the incoming nibble and apply the optional injection mask.
  always_comb begin
    d1 = bus.in_data[3];
    d2 = bus.in_data[2];
    d3 = bus.in_data[1];
    d4 = bus.in_data[0];
    p1 = d1 ^ d2 ^ d4 ^ bus.select;
    p2 = d1 ^ d3 ^ d4 ^ bus.select;
    p4 = d2 ^ d3 ^ d4 ^ bus.select;
    inj_mask = 7'b0000000;
    if (INJ_EN) begin
      case (bus.inj_pos)
        3'd1:    inj_mask = 7'b1000000;
        3'd2:    inj_mask = 7'b0100000;
        3'd3:    inj_mask = 7'b0010000;
        3'd4:    inj_mask = 7'b0001000;
        3'd5:    inj_mask = 7'b0000100;
        3'd6:    inj_mask = 7'b0000010;
        3'd7:    inj_mask = 7'b0000001;
        default: inj_mask = 7'b0000000;
      endcase
    end
    cw_enc = {p1, p2, d1, p4, d2, d3, d4} ^ inj_mask;
  end

  // State register plus FIFO storage, ready flop and accept counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      head_q     <= 7'b0000000;
      tail_q     <= 7'b0000000;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state: occupancy transitions and where a pushed word lands.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          state_d = StOne;
          head_d  = cw_enc;
        end
      end
      StOne: begin
        if (push && pop) begin
          head_d = cw_enc;
        end else if (push) begin
          state_d = StFull;
          tail_d  = cw_enc;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // push cannot happen here since in_ready is low
        if (pop) begin
          state_d = StOne;
          head_d  = tail_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // ready is a flop so it never depends combinationally on out_ready
    in_ready_d = (state_d != StFull);
    cnt_d      = push ? cnt_q + 1'b1 : cnt_q;
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.out_valid = (state_q != StEmpty);
    bus.out_data  = head_q;
    bus.in_ready  = in_ready_q;
    cw_count      = cnt_q;
  end

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Directed bench for hamming_stream_encoder: table of single-word encodings plus
// hand-written backpressure, back-to-back and mid-stream reset sequences.
module tb_hamming_stream_encoder;

  logic        clk;
  logic        rst_n;
  logic [15:0] cw_count;
  int          total;
  int          bad;
  int          exp_cnt;

  hamming_stream_encoder_if bus ();

  hamming_stream_encoder #(
    .CNT_W (16),
    .INJ_EN(1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .cw_count(cw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       sel;
    logic [2:0] inj;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Golden model: parity bits cover codeword positions by their binary index.
  function automatic logic [6:0] golden(input logic [3:0] d, input logic sel, input logic [2:0] inj);
    logic [7:1] pos;
    logic [6:0] cw;
    pos[3] = d[3];
    pos[5] = d[2];
    pos[6] = d[1];
    pos[7] = d[0];
    pos[1] = pos[3] ^ pos[5] ^ pos[7] ^ sel;
    pos[2] = pos[3] ^ pos[6] ^ pos[7] ^ sel;
    pos[4] = pos[5] ^ pos[6] ^ pos[7] ^ sel;
    if (inj != 3'd0) pos[inj] = ~pos[inj];
    for (int k = 1; k <= 7; k++) cw[7-k] = pos[k];
    return cw;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    exp_cnt       = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'd0;
    bus.select    = 1'b0;
    bus.inj_pos   = 3'd0;
    bus.out_ready = 1'b1;

    vecs[0] = '{4'b1011, 1'b0, 3'd0, 7'b0110011};
    vecs[1] = '{4'b1011, 1'b1, 3'd0, 7'b1011011};
    vecs[2] = '{4'b0000, 1'b1, 3'd0, 7'b1101000};
    vecs[3] = '{4'b0000, 1'b0, 3'd0, 7'b0000000};
    vecs[4] = '{4'b1011, 1'b0, 3'd3, 7'b0100011};
    vecs[5] = '{4'b1011, 1'b0, 3'd7, 7'b0110010};
    vecs[6] = '{4'b1101, 1'b0, 3'd0, 7'b1010101};
    vecs[7] = '{4'b1111, 1'b0, 3'd0, 7'b1111111};
    vecs[8] = '{4'b1111, 1'b1, 3'd1, 7'b1010111};

    tick();
    tick();
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset out_data", {25'd0, bus.out_data}, 32'd0);
    check("reset cw_count", {16'd0, cw_count}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single-word encodings, FIFO empty each time.
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vecs[i].data;
      bus.select   = vecs[i].sel;
      bus.inj_pos  = vecs[i].inj;
      tick();
      bus.in_valid = 1'b0;
      exp_cnt++;
      check($sformatf("vec%0d out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("vec%0d out_data", i), {25'd0, bus.out_data}, {25'd0, vecs[i].exp});
      tick();
      check($sformatf("vec%0d drained", i), {31'd0, bus.out_valid}, 32'd0);
    end
    check("count after table", {16'd0, cw_count}, exp_cnt);

    // Backpressure: three words with the consumer stalled.
    bus.out_ready = 1'b0;
    bus.select    = 1'b0;
    bus.inj_pos   = 3'd0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'b1101;
    tick();
    check("bp ready after 1", {31'd0, bus.in_ready}, 32'd1);
    check("bp head after 1", {25'd0, bus.out_data}, {25'd0, 7'b1010101});
    bus.in_data = 4'b1011;
    tick();
    check("bp ready after 2", {31'd0, bus.in_ready}, 32'd0);
    bus.in_data = 4'b0000;
    tick();
    check("bp ready stalled", {31'd0, bus.in_ready}, 32'd0);
    check("bp head held", {25'd0, bus.out_data}, {25'd0, 7'b1010101});
    check("bp valid held", {31'd0, bus.out_valid}, 32'd1);
    exp_cnt += 2;
    check("bp count", {16'd0, cw_count}, exp_cnt);
    bus.out_ready = 1'b1;
    tick();
    check("bp second word", {25'd0, bus.out_data}, {25'd0, 7'b0110011});
    check("bp ready back", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    exp_cnt++;
    check("bp third word", {25'd0, bus.out_data}, {25'd0, 7'b0000000});
    check("bp third valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp count final", {16'd0, cw_count}, exp_cnt);
    tick();
    check("bp drained", {31'd0, bus.out_valid}, 32'd0);

    // Reset mid-stream with the FIFO full and handshakes active.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'b0101;
    tick();
    bus.in_data = 4'b0110;
    tick();
    check("full before reset", {31'd0, bus.in_ready}, 32'd0);
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    check("midrst out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst cw_count", {16'd0, cw_count}, 32'd0);
    check("midrst out_data", {25'd0, bus.out_data}, 32'd0);
    exp_cnt = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b1001;
    bus.select   = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    exp_cnt++;
    check("post rst word", {25'd0, bus.out_data}, {25'd0, golden(4'b1001, 1'b1, 3'd0)});
    check("post rst count", {16'd0, cw_count}, exp_cnt);
    tick();

    // Back-to-back: 16 nibbles with the consumer always ready.
    do_reset();
    bus.select    = 1'b0;
    bus.inj_pos   = 3'd0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 4'(i);
      tick();
      check($sformatf("b2b%0d valid", i), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("b2b%0d ready", i), {31'd0, bus.in_ready}, 32'd1);
      check($sformatf("b2b%0d data", i), {25'd0, bus.out_data},
            {25'd0, golden(4'(i), 1'b0, 3'd0)});
    end
    bus.in_valid = 1'b0;
    check("b2b count", {16'd0, cw_count}, 32'd16);
    tick();
    check("b2b drained", {31'd0, bus.out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
